// File: rtl/vproc_instr_queue.sv
// Instruction queue between the vector decoder and the dispatcher.
// Circular buffer of decoded instructions plus their vreg write maps; also
// exports the OR of all queued write maps for upstream hazard lookahead.
// Optional macro VPROC_INSTR_QUEUE_BYPASS_EN: when empty, an incoming
// instruction is presented at the dequeue side in the same cycle.
module vproc_instr_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned MAX_VADDR_W = 5
) (
    input  logic                            clk_i,
    input  logic                            async_rst_ni,
    input  logic                            sync_rst_ni,
    input  logic                            flush_i,
    input  logic                            enq_valid_i,
    output logic                            enq_ready_o,
    input  logic [DATA_W-1:0]               enq_data_i,
    input  logic [(1 << MAX_VADDR_W)-1:0]   enq_vreg_wr_i,
    output logic                            deq_valid_o,
    input  logic                            deq_ready_i,
    output logic [DATA_W-1:0]               deq_data_o,
    output logic [(1 << MAX_VADDR_W)-1:0]   deq_vreg_wr_o,
    output logic [(1 << MAX_VADDR_W)-1:0]   queued_vreg_wr_o,
    output logic [$clog2(DEPTH + 1)-1:0]    count_o
);

    localparam int unsigned VADDR_CNT = 1 << MAX_VADDR_W;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]    r_data [DEPTH];
    logic [VADDR_CNT-1:0] r_map  [DEPTH];

    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [CNT_W-1:0]     r_count;

    logic [PTR_W-1:0]     w_rd_ptr_d;
    logic [PTR_W-1:0]     w_wr_ptr_d;
    logic [CNT_W-1:0]     w_count_d;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_store_enq;
    logic                 w_store_deq;
    logic [PTR_W-1:0]     w_offs;
    logic [VADDR_CNT-1:0] w_queued;

    // Handshake outputs, head selection and storage push/pop strobes
    always_comb begin
        w_empty       = (r_count == '0);
        w_full        = (r_count == CNT_W'(DEPTH));
        enq_ready_o   = ~w_full & ~flush_i;
        deq_valid_o   = ~w_empty & ~flush_i;
        deq_data_o    = r_data[r_rd_ptr];
        deq_vreg_wr_o = r_map[r_rd_ptr];
        w_store_enq   = enq_valid_i & enq_ready_o;
        w_store_deq   = ~w_empty & ~flush_i & deq_ready_i;
`ifdef VPROC_INSTR_QUEUE_BYPASS_EN
        // Empty queue: hand the incoming instruction straight through
        if (w_empty & ~flush_i) begin
            deq_valid_o   = enq_valid_i;
            deq_data_o    = enq_data_i;
            deq_vreg_wr_o = enq_vreg_wr_i;
            w_store_enq   = enq_valid_i & enq_ready_o & ~deq_ready_i;
        end
`endif
    end

    // Next pointer/count; flush clears the queue and suppresses both sides
    always_comb begin
        w_rd_ptr_d = r_rd_ptr + PTR_W'(w_store_deq);
        w_wr_ptr_d = r_wr_ptr + PTR_W'(w_store_enq);
        w_count_d  = r_count + CNT_W'(w_store_enq) - CNT_W'(w_store_deq);
        if (flush_i) begin
            w_rd_ptr_d = '0;
            w_wr_ptr_d = '0;
            w_count_d  = '0;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (!sync_rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_d;
            r_wr_ptr <= w_wr_ptr_d;
            r_count  <= w_count_d;
        end
    end

    // Entry storage, intentionally without reset
    always_ff @(posedge clk_i) begin
        if (w_store_enq) begin
            r_data[r_wr_ptr] <= enq_data_i;
            r_map[r_wr_ptr]  <= enq_vreg_wr_i;
        end
    end

    // OR of write maps of the entries between rd_ptr and rd_ptr+count
    always_comb begin
        w_queued = '0;
        w_offs   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_offs = PTR_W'(i) - r_rd_ptr;
            if (CNT_W'(w_offs) < r_count) begin
                w_queued = w_queued | r_map[i];
            end
        end
    end

    assign queued_vreg_wr_o = w_queued;
    assign count_o          = r_count;

`ifndef SYNTHESIS
    localparam bit DEPTH_POW2 = (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0);

    // Circular indexing relies on natural pointer wrap
    a_depth_pow2: assert property (@(posedge clk_i) DEPTH_POW2)
        else $error("vproc_instr_queue: DEPTH must be a power of two >= 2");

    // A held-off instruction must not change until it is accepted
    a_enq_stable: assert property (@(posedge clk_i) disable iff (!async_rst_ni)
        (enq_valid_i & ~enq_ready_o & ~flush_i & sync_rst_ni) |=> $stable(enq_data_i))
        else $error("vproc_instr_queue: enq_data_i changed while held off");
`endif

endmodule

// File: tb/tb_vproc_instr_queue.sv
// Self-checking bench for vproc_instr_queue: directed scenarios followed by
// random traffic, all checked against a queue-based transaction model.
module tb_vproc_instr_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        async_rst_ni;
    logic        sync_rst_ni;
    logic        flush_i;
    logic        enq_valid_i;
    logic        enq_ready_o;
    logic [63:0] enq_data_i;
    logic [31:0] enq_vreg_wr_i;
    logic        deq_valid_o;
    logic        deq_ready_i;
    logic [63:0] deq_data_o;
    logic [31:0] deq_vreg_wr_o;
    logic [31:0] queued_vreg_wr_o;
    logic [2:0]  count_o;

    vproc_instr_queue #(.DEPTH(DEPTH), .DATA_W(64), .MAX_VADDR_W(5)) dut (
        .clk_i           (clk_i),
        .async_rst_ni    (async_rst_ni),
        .sync_rst_ni     (sync_rst_ni),
        .flush_i         (flush_i),
        .enq_valid_i     (enq_valid_i),
        .enq_ready_o     (enq_ready_o),
        .enq_data_i      (enq_data_i),
        .enq_vreg_wr_i   (enq_vreg_wr_i),
        .deq_valid_o     (deq_valid_o),
        .deq_ready_i     (deq_ready_i),
        .deq_data_o      (deq_data_o),
        .deq_vreg_wr_o   (deq_vreg_wr_o),
        .queued_vreg_wr_o(queued_vreg_wr_o),
        .count_o         (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [63:0] d;
        logic [31:0] m;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic        g_held = 1'b0;
    logic [63:0] cur_d;
    logic [31:0] cur_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model at negedge, advance model at posedge
    task automatic step(input logic fl, input logic ev, input logic [63:0] d,
                        input logic [31:0] m, input logic dr, input logic srst);
        int   n;
        logic e_ready, e_valid, byp, deq_f, enq_f;
        ent_t head;
        logic [31:0] e_q;
        flush_i       = fl;
        enq_valid_i   = ev;
        enq_data_i    = d;
        enq_vreg_wr_i = m;
        deq_ready_i   = dr;
        sync_rst_ni   = srst;
        @(negedge clk_i);
        n       = q.size();
        e_ready = (n != DEPTH) && !fl;
        e_valid = (n != 0) && !fl;
        head    = '0;
        if (n != 0) head = q[0];
        byp = 1'b0;
`ifdef VPROC_INSTR_QUEUE_BYPASS_EN
        byp = (n == 0) && !fl;
        if (byp) begin
            e_valid = ev;
            head    = '{d: d, m: m};
        end
`endif
        e_q = '0;
        foreach (q[i]) e_q = e_q | q[i].m;
        chk("count", 64'(count_o), 64'(n));
        chk("enq_ready", 64'(enq_ready_o), 64'(e_ready));
        chk("deq_valid", 64'(deq_valid_o), 64'(e_valid));
        chk("queued_map", 64'(queued_vreg_wr_o), 64'(e_q));
        if (e_valid) begin
            chk("deq_data", deq_data_o, head.d);
            chk("deq_map", 64'(deq_vreg_wr_o), 64'(head.m));
        end
        deq_f  = e_valid && dr;
        enq_f  = ev && e_ready;
        g_held = ev && !e_ready && !fl;
        @(posedge clk_i);
        if (!srst || fl) begin
            q.delete();
        end else if (byp && deq_f) begin
            // consumed directly from the enqueue side
        end else begin
            if (deq_f) void'(q.pop_front());
            if (enq_f) q.push_back('{d: d, m: m});
        end
        #1;
    endtask

    task automatic new_payload();
        if (!g_held) begin
            cur_d = {$urandom, $urandom};
            cur_m = $urandom;
        end
    endtask

    initial begin
        async_rst_ni  = 1'b0;
        sync_rst_ni   = 1'b1;
        flush_i       = 1'b0;
        enq_valid_i   = 1'b0;
        enq_data_i    = '0;
        enq_vreg_wr_i = '0;
        deq_ready_i   = 1'b0;
        #1;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready_o), 64'd1);
        chk("rst_deq_valid", 64'(deq_valid_o), 64'd0);
        chk("rst_queued", 64'(queued_vreg_wr_o), 64'd0);
        #11 async_rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // 1: single push with consumer ready
        step(0, 1, 64'h11, 32'h2, 1, 1);
`ifdef VPROC_INSTR_QUEUE_BYPASS_EN
        chk("t1_count_after_push", 64'(count_o), 64'd0);
`else
        chk("t1_count_after_push", 64'(count_o), 64'd1);
`endif
        step(0, 0, 64'h0, 32'h0, 1, 1);
        chk("t1_count_drained", 64'(count_o), 64'd0);

        // 2: fill to DEPTH, fifth is held off
        for (int i = 0; i < 4; i++) step(0, 1, 64'(i + 1), 32'(1 << i), 0, 1);
        chk("t2_count_full", 64'(count_o), 64'd4);
        chk("t2_queued_full", 64'(queued_vreg_wr_o), 64'hF);
        step(0, 1, 64'h55, 32'h10, 0, 1);

        // 3: drain one from full; ready returns only on the next cycle
        step(0, 1, 64'h55, 32'h10, 1, 1);
        step(0, 1, 64'h55, 32'h10, 0, 1);
        chk("t3_refilled", 64'(count_o), 64'd4);
        g_held = 1'b0;
        for (int i = 0; i < 10; i++) begin
            new_payload();
            step(0, 1, cur_d, cur_m, 1, 1);
        end
        for (int i = 0; i < 5; i++) step(0, 0, 64'h0, 32'h0, 1, 1);
        chk("t3_empty", 64'(count_o), 64'd0);

        // 4: steady enqueue+dequeue at count 2
        g_held = 1'b0;
        step(0, 1, 64'hA1, 32'h100, 0, 1);
        step(0, 1, 64'hA2, 32'h200, 0, 1);
        for (int i = 0; i < 5; i++) begin
            new_payload();
            step(0, 1, cur_d, cur_m, 1, 1);
        end
        chk("t4_count", 64'(count_o), 64'd2);

        // 5: flush at count 3 with a concurrent enqueue
        step(0, 1, 64'hB3, 32'h400, 0, 1);
        step(1, 1, 64'hB4, 32'h800, 1, 1);
        chk("t5_count", 64'(count_o), 64'd0);
        chk("t5_queued", 64'(queued_vreg_wr_o), 64'd0);
        step(0, 0, 64'h0, 32'h0, 0, 1);

        // 6: async reset mid-stream at count 2
        step(0, 1, 64'hC1, 32'h1, 0, 1);
        step(0, 1, 64'hC2, 32'h2, 0, 1);
        enq_valid_i = 1'b0;
        #2 async_rst_ni = 1'b0;
        #1;
        chk("t6_count", 64'(count_o), 64'd0);
        chk("t6_enq_ready", 64'(enq_ready_o), 64'd1);
        chk("t6_deq_valid", 64'(deq_valid_o), 64'd0);
        chk("t6_queued", 64'(queued_vreg_wr_o), 64'd0);
        q.delete();
        g_held = 1'b0;
        @(negedge clk_i); #2 async_rst_ni = 1'b1;
        @(posedge clk_i); #1;
        step(0, 1, 64'hABCD, 32'h4, 0, 1);
        step(0, 0, 64'h0, 32'h0, 1, 1);
        step(0, 0, 64'h0, 32'h0, 0, 1);

        // Random traffic including occasional flush and synchronous reset
        g_held = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic ev, dr, fl, sr;
            new_payload();
            ev = g_held ? 1'b1 : ($urandom_range(0, 9) < 7);
            dr = ($urandom_range(0, 9) < 6);
            fl = ($urandom_range(0, 19) == 0);
            sr = ($urandom_range(0, 29) != 0);
            step(fl, ev, cur_d, cur_m, dr, sr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
